// File: rtl/shift_subtract_divider_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/shift_subtract_divider_if.sv
// Start/done handshake and operand/result bundle between the requester and the divider.
interface shift_subtract_divider_if #(
  parameter int N = 32
) ();

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/shift_subtract_divider_sub_stage.sv
// Ripple subtractor for the trial step, chained from 1-bit add/sub cells with op fixed to subtract.
module div_addsub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic op_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  logic b_x;

  assign b_x    = b_i ^ op_i;
  assign s_o    = a_i ^ b_x ^ cin_i;
  assign cout_o = (a_i & b_x) | (cin_i & (a_i ^ b_x));

endmodule

module div_sub_stage #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_n_o
);

  localparam logic OP_SUB = 1'b1;

  logic [W:0] carry;

  // op=1 inverts b inside each cell; the same bit supplies the +1 at the LSB
  assign carry[0] = OP_SUB;

  for (genvar i = 0; i < W; i++) begin : g_cell
    div_addsub_cell u_cell (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .op_i   (OP_SUB),
      .cin_i  (carry[i]),
      .s_o    (diff_o[i]),
      .cout_o (carry[i+1])
    );
  end

  assign borrow_n_o = carry[W];

endmodule

// File: rtl/shift_subtract_divider.sv
// Sequential unsigned N-bit restoring divider, one shift + trial subtract per cycle.
//   state    | meaning
//   DIV_IDLE | waiting for start
//   DIV_RUN  | iterating, count_q steps left
//   DIV_DONE | done pulse, results valid; start here is accepted back-to-back
module shift_subtract_divider
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  shift_subtract_divider_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     r_q, r_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     d_q, d_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [N-1:0]     rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [N:0]       trial_a;
  logic [N:0]       trial_b;
  logic [N:0]       trial_diff;
  logic             trial_borrow_n;
  logic             trial_ok;
  logic [N-1:0]     r_step;
  logic [N-1:0]     q_step;
  logic             accept;

  assign trial_a = {r_q, q_q[N-1]};
  assign trial_b = {1'b0, d_q};

  div_sub_stage #(.W(N + 1)) u_sub (
    .a_i        (trial_a),
    .b_i        (trial_b),
    .diff_o     (trial_diff),
    .borrow_n_o (trial_borrow_n)
  );

  // R < D holds between steps, so the partial remainder always fits in N bits
  assign trial_ok = trial_borrow_n & ~trial_diff[N];
  assign r_step   = trial_ok ? trial_diff[N-1:0] : trial_a[N-1:0];
  assign q_step   = {q_q[N-2:0], trial_ok};
  assign accept   = bus.start && (state_q == DIV_IDLE || state_q == DIV_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      DIV_RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DIV_DONE;
          done_d  = 1'b1;
          quo_d   = q_step;
          rem_d   = r_step;
          dbz_d   = 1'b0;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default: ;
    endcase

    if (accept) begin
      r_d   = '0;
      q_d   = bus.dividend;
      d_d   = bus.divisor;
      cnt_d = CNT_W'(N);
      if (bus.divisor == '0) begin
        state_d = DIV_DONE;
        done_d  = 1'b1;
        quo_d   = '1;
        rem_d   = bus.dividend;
        dbz_d   = 1'b1;
      end else begin
        state_d = DIV_RUN;
      end
    end

    busy_d = (state_d == DIV_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_subtract_divider.sv
// Self-checking bench: directed N=8 cases plus randomized N=32 traffic against an arithmetic model.
module tb_shift_subtract_divider;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  shift_subtract_divider_if #(.N(8))  bus8 ();
  shift_subtract_divider_if #(.N(32)) bus32 ();

  shift_subtract_divider #(.N(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  shift_subtract_divider #(.N(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Waits at negedges from the cycle after acceptance; checks the result on the done cycle.
  task automatic verify8(input logic [7:0] a, input logic [7:0] b, input int exp_busy, input string tag);
    int busy_n   = 0;
    bit seen     = 0;
    bit overlap  = 0;
    logic [7:0] eq, er;
    for (int i = 0; i < 40; i++) begin
      if (bus8.busy && bus8.done) overlap = 1;
      if (bus8.done) begin
        seen = 1;
        break;
      end
      if (bus8.busy) busy_n++;
      @(negedge clk);
    end
    if (b == 0) begin
      eq = 8'hFF;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    check({tag, ".done"}, 64'(seen), 64'd1);
    check({tag, ".busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    check({tag, ".busy_done_overlap"}, 64'(overlap), 64'd0);
    check({tag, ".quotient"}, 64'(bus8.quotient), 64'(eq));
    check({tag, ".remainder"}, 64'(bus8.remainder), 64'(er));
    check({tag, ".div_by_zero"}, 64'(bus8.div_by_zero), 64'(b == 0));
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus8.start    = 1'b1;
    bus8.dividend = a;
    bus8.divisor  = b;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [7:0] q_at_done, r_at_done;
    issue8(a, b);
    verify8(a, b, (b == 0) ? 0 : 8, tag);
    q_at_done = bus8.quotient;
    r_at_done = bus8.remainder;
    @(negedge clk);
    check({tag, ".done_one_cycle"}, 64'(bus8.done), 64'd0);
    repeat (3) @(negedge clk);
    check({tag, ".held"}, {48'd0, bus8.quotient, bus8.remainder}, {48'd0, q_at_done, r_at_done});
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b);
    int busy_n = 0;
    bit seen   = 0;
    logic [31:0] eq, er;
    @(negedge clk);
    bus32.start    = 1'b1;
    bus32.dividend = a;
    bus32.divisor  = b;
    @(negedge clk);
    bus32.start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus32.done) begin
        seen = 1;
        break;
      end
      if (bus32.busy) busy_n++;
      @(negedge clk);
    end
    if (b == 0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    check("r32.done", 64'(seen), 64'd1);
    check("r32.busy_cycles", 64'(busy_n), (b == 0) ? 64'd0 : 64'd32);
    check("r32.quotient", 64'(bus32.quotient), 64'(eq));
    check("r32.remainder", 64'(bus32.remainder), 64'(er));
    check("r32.div_by_zero", 64'(bus32.div_by_zero), 64'(b == 0));
    if (b != 0) begin
      check("r32.invariant", 64'(bus32.quotient) * 64'(b) + 64'(bus32.remainder), 64'(a));
      check("r32.rem_lt_div", 64'(bus32.remainder < b), 64'd1);
    end
  endtask

  initial begin
    int done_seen;
    logic [31:0] ra, rb;
    int sel;

    rst_n          = 1'b0;
    bus8.start     = 1'b0;
    bus8.dividend  = '0;
    bus8.divisor   = '0;
    bus32.start    = 1'b0;
    bus32.dividend = '0;
    bus32.divisor  = '0;

    repeat (2) @(negedge clk);
    check("reset.out8", {29'd0, bus8.busy, bus8.done, bus8.div_by_zero, 16'd0, bus8.quotient, bus8.remainder}, 64'd0);
    check("reset.out32", {bus32.quotient, bus32.remainder}, 64'd0);
    rst_n = 1'b1;

    op8(8'd100, 8'd7, "d100_7");
    op8(8'd42, 8'd0, "d42_0");
    op8(8'd5, 8'd9, "d5_9");
    op8(8'd255, 8'd1, "d255_1");
    op8(8'd255, 8'd255, "d255_255");

    // start during RUN is ignored; start on the done cycle is taken back-to-back
    issue8(8'd100, 8'd7);
    @(negedge clk);
    bus8.start    = 1'b1;
    bus8.dividend = 8'd9;
    bus8.divisor  = 8'd3;
    @(negedge clk);
    bus8.start = 1'b0;
    verify8(8'd100, 8'd7, 6, "mid_run_ignored");
    bus8.start    = 1'b1;
    bus8.dividend = 8'd77;
    bus8.divisor  = 8'd5;
    @(negedge clk);
    bus8.start = 1'b0;
    verify8(8'd77, 8'd5, 8, "back_to_back");

    // reset pulse at RUN step 4 aborts the operation
    issue8(8'd250, 8'd3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.outputs_zero",
          {29'd0, bus8.busy, bus8.done, bus8.div_by_zero, 16'd0, bus8.quotient, bus8.remainder}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) done_seen++;
    end
    check("abort.no_done", 64'(done_seen), 64'd0);
    op8(8'd200, 8'd13, "d200_13");

    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'h8000_0000;
        3:       rb = 32'hFFFF_FFFF;
        4:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
      op32(ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
